// File: rtl/hs_buffer_fifo.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | hs_buffer_fifo: DEPTH-entry first-word-fall-through valid/ready     |
// | buffer with occupancy output and optional zero-beat discard.        |
// | Revision: 1.0                                                       |
// +--------------------------------------------------------------------+
module hs_buffer_fifo #(
    parameter int DATA_W    = 32,
    parameter int DEPTH     = 4,
    parameter int ADDR_W    = 2,
    parameter int DROP_ZERO = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [DATA_W-1:0] s_data,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [DATA_W-1:0] m_data,
    output logic [ADDR_W:0]   level,
    output logic [15:0]       drop_cnt
);

    localparam logic [ADDR_W:0] FULL_LEVEL = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W:0] LEVEL_ONE  = (ADDR_W + 1)'(1);
    localparam logic [15:0]     DROP_MAX   = 16'hFFFF;
    localparam bit              DROP_EN    = (DROP_ZERO != 0);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W:0]   level_q, level_d;
    logic [15:0]       drop_cnt_q, drop_cnt_d;

    logic full;
    logic empty;
    logic push;
    logic drop;
    logic push_eff;
    logic pop;

    assign full     = (level_q == FULL_LEVEL);
    assign empty    = (level_q == '0);
    assign s_ready  = !full && !reset;
    assign m_valid  = !empty;
    assign m_data   = m_valid ? mem_q[rd_ptr_q] : '0;
    assign level    = level_q;
    assign drop_cnt = drop_cnt_q;

    // A dropped zero beat still completes the handshake; it just never lands in memory.
    assign push     = s_valid && s_ready;
    assign drop     = push && DROP_EN && (s_data == '0);
    assign push_eff = push && !drop;
    assign pop      = m_valid && m_ready;

    always_comb begin
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        level_d    = level_q;
        drop_cnt_d = drop_cnt_q;

        if (push_eff) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        if (push_eff && !pop) begin
            level_d = level_q + LEVEL_ONE;
        end else if (pop && !push_eff) begin
            level_d = level_q - LEVEL_ONE;
        end
        if (drop && (drop_cnt_q != DROP_MAX)) begin
            drop_cnt_d = drop_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            level_q    <= '0;
            drop_cnt_q <= '0;
        end else begin
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            level_q    <= level_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    // Storage is not reset; stale contents are unreachable once the pointers clear.
    always_ff @(posedge clk) begin
        if (push_eff) begin
            mem_q[wr_ptr_q] <= s_data;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_hs_buffer_fifo.sv
`default_nettype none
// Bench for hs_buffer_fifo: directed and random traffic on a 32x4 drop-zero
// instance and an 8x8 instance, checked by a queue-based scoreboard.
module tb_hs_buffer_fifo;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Instance A: DATA_W=32, DEPTH=4, DROP_ZERO=1
    logic        a_rst = 1'b1;
    logic        a_sv  = 1'b0;
    logic [31:0] a_sd  = '0;
    logic        a_mr  = 1'b0;
    logic        a_s_ready, a_m_valid;
    logic [31:0] a_m_data;
    logic [2:0]  a_level;
    logic [15:0] a_drop_cnt;

    // Instance B: DATA_W=8, DEPTH=8, DROP_ZERO=0
    logic        b_rst = 1'b1;
    logic        b_sv  = 1'b0;
    logic [7:0]  b_sd  = '0;
    logic        b_mr  = 1'b0;
    logic        b_s_ready, b_m_valid;
    logic [7:0]  b_m_data;
    logic [3:0]  b_level;
    logic [15:0] b_drop_cnt;

    hs_buffer_fifo #(.DATA_W(32), .DEPTH(4), .ADDR_W(2), .DROP_ZERO(1)) u_a (
        .clk(clk), .reset(a_rst),
        .s_valid(a_sv), .s_ready(a_s_ready), .s_data(a_sd),
        .m_valid(a_m_valid), .m_ready(a_mr), .m_data(a_m_data),
        .level(a_level), .drop_cnt(a_drop_cnt)
    );

    hs_buffer_fifo #(.DATA_W(8), .DEPTH(8), .ADDR_W(3), .DROP_ZERO(0)) u_b (
        .clk(clk), .reset(b_rst),
        .s_valid(b_sv), .s_ready(b_s_ready), .s_data(b_sd),
        .m_valid(b_m_valid), .m_ready(b_mr), .m_data(b_m_data),
        .level(b_level), .drop_cnt(b_drop_cnt)
    );

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: a FIFO is just an ordered queue of stored beats.
    logic [31:0] qa[$];
    logic [7:0]  qb[$];
    int          a_drops = 0;
    logic        a_exp_rdy, b_exp_rdy;
    logic [31:0] a_exp_data;
    logic [7:0]  b_exp_data;

    always @(negedge clk) begin
        a_exp_rdy  = !a_rst && (qa.size() < 4);
        a_exp_data = (qa.size() != 0) ? qa[0] : 32'h0;
        check("a_s_ready",  32'(a_s_ready),  32'(a_exp_rdy));
        check("a_m_valid",  32'(a_m_valid),  32'(qa.size() != 0));
        check("a_m_data",   a_m_data,        a_exp_data);
        check("a_level",    32'(a_level),    32'(qa.size()));
        check("a_drop_cnt", 32'(a_drop_cnt), 32'(a_drops));
        if (a_rst) begin
            qa.delete();
            a_drops = 0;
        end else begin
            if (a_mr && qa.size() != 0) void'(qa.pop_front());
            if (a_sv && a_exp_rdy) begin
                if (a_sd == 32'h0) begin
                    if (a_drops < 65535) a_drops++;
                end else begin
                    qa.push_back(a_sd);
                end
            end
        end
    end

    always @(negedge clk) begin
        b_exp_rdy  = !b_rst && (qb.size() < 8);
        b_exp_data = (qb.size() != 0) ? qb[0] : 8'h0;
        check("b_s_ready",  32'(b_s_ready),  32'(b_exp_rdy));
        check("b_m_valid",  32'(b_m_valid),  32'(qb.size() != 0));
        check("b_m_data",   32'(b_m_data),   32'(b_exp_data));
        check("b_level",    32'(b_level),    32'(qb.size()));
        check("b_drop_cnt", 32'(b_drop_cnt), 32'h0);
        if (b_rst) begin
            qb.delete();
        end else begin
            if (b_mr && qb.size() != 0) void'(qb.pop_front());
            if (b_sv && b_exp_rdy) qb.push_back(b_sd);
        end
    end

    // One clock of stimulus on A; acc reports whether the beat was taken at this edge.
    task automatic a_cyc(input logic v, input logic [31:0] d, input logic r, output logic acc);
        a_sv = v;
        a_sd = d;
        a_mr = r;
        @(negedge clk);
        acc = a_sv && a_s_ready;
        @(posedge clk);
        #1;
    endtask

    task automatic b_cyc(input logic v, input logic [7:0] d, input logic r, output logic acc);
        b_sv = v;
        b_sd = d;
        b_mr = r;
        @(negedge clk);
        acc = b_sv && b_s_ready;
        @(posedge clk);
        #1;
    endtask

    task automatic a_drain(input string nm);
        logic acc;
        for (int i = 0; i < 40 && (qa.size() != 0 || a_m_valid); i++) a_cyc(1'b0, 32'h0, 1'b1, acc);
        a_cyc(1'b0, 32'h0, 1'b0, acc);
        check(nm, 32'(a_level), 32'h0);
    endtask

    initial begin
        logic        acc;
        logic        pend;
        logic [31:0] d32;
        logic [7:0]  d8;
        int          beats;
        int          cyc;

        repeat (2) @(posedge clk);
        #1;
        a_rst = 1'b0;
        b_rst = 1'b0;

        // Three pushes with no drain; head stays at the first beat.
        a_cyc(1'b1, 32'h11, 1'b0, acc);
        a_cyc(1'b1, 32'h22, 1'b0, acc);
        a_cyc(1'b1, 32'h33, 1'b0, acc);
        a_cyc(1'b0, 32'h0,  1'b0, acc);
        check("t1_level", 32'(a_level), 32'd3);
        check("t1_head",  a_m_data,     32'h11);
        a_drain("t1_drain");

        // Fill, hold a fifth beat while full, free one slot, then drain the rest.
        for (int i = 1; i <= 4; i++) a_cyc(1'b1, 32'(i), 1'b0, acc);
        a_cyc(1'b1, 32'h55, 1'b0, acc);
        check("t2_full_hold", 32'(acc), 32'h0);
        a_cyc(1'b1, 32'h55, 1'b1, acc);
        check("t2_no_push_on_pop", 32'(acc), 32'h0);
        a_cyc(1'b1, 32'h55, 1'b0, acc);
        check("t2_accept_after", 32'(acc), 32'h1);
        check("t2_head", a_m_data, 32'h2);
        a_drain("t2_drain");

        // Streaming after a single-beat prefill keeps occupancy at one.
        a_cyc(1'b1, 32'h64, 1'b0, acc);
        for (int i = 1; i <= 20; i++) begin
            a_cyc(1'b1, 32'(i), 1'b1, acc);
            check("t3_stream_acc", 32'(acc), 32'h1);
        end
        check("t3_level", 32'(a_level), 32'd1);
        a_drain("t3_drain");

        // Zero beats are consumed but not stored.
        a_cyc(1'b1, 32'h7, 1'b0, acc);
        a_cyc(1'b1, 32'h0, 1'b0, acc);
        a_cyc(1'b1, 32'h0, 1'b0, acc);
        a_cyc(1'b1, 32'h9, 1'b0, acc);
        a_cyc(1'b0, 32'h0, 1'b0, acc);
        check("t4_drop_cnt", 32'(a_drop_cnt), 32'd2);
        check("t4_level",    32'(a_level),    32'd2);
        a_drain("t4_drain");

        // Mid-operation reset discards contents; s_valid during reset is ignored.
        for (int i = 0; i < 3; i++) a_cyc(1'b1, 32'(i + 8'hC0), 1'b0, acc);
        a_rst = 1'b1;
        a_cyc(1'b1, 32'h77, 1'b0, acc);
        a_rst = 1'b0;
        check("t5_level",  32'(a_level),  32'h0);
        check("t5_m_data", a_m_data,      32'h0);
        check("t5_drops",  32'(a_drop_cnt), 32'h0);
        a_cyc(1'b1, 32'hA5, 1'b0, acc);
        a_cyc(1'b0, 32'h0, 1'b0, acc);
        check("t5_head", a_m_data, 32'hA5);
        a_drain("t5_drain");

        // Random traffic on A with frequent zero beats.
        pend = 1'b0;
        d32  = '0;
        for (int i = 0; i < 400; i++) begin
            if (!pend) d32 = 32'($urandom_range(0, 3));
            if (!pend) pend = ($urandom_range(0, 3) != 0);
            a_cyc(pend, d32, ($urandom_range(0, 2) != 0), acc);
            if (acc) pend = 1'b0;
        end
        a_sv = 1'b0;
        a_drain("a_rand_drain");

        // Random back-pressure on B for 1000 accepted beats.
        beats = 0;
        cyc   = 0;
        pend  = 1'b0;
        d8    = '0;
        while (beats < 1000 && cyc < 20000) begin
            if (!pend) begin
                d8   = 8'($urandom);
                pend = ($urandom_range(0, 9) < 7);
            end
            b_cyc(pend, d8, ($urandom_range(0, 9) < 6), acc);
            if (acc) begin
                pend = 1'b0;
                beats++;
            end
            cyc++;
        end
        check("b_beats", 32'(beats), 32'd1000);
        cyc = 0;
        while ((qb.size() != 0 || b_m_valid) && cyc < 100) begin
            b_cyc(1'b0, 8'h0, 1'b1, acc);
            cyc++;
        end
        b_cyc(1'b0, 8'h0, 1'b0, acc);
        check("b_drain", 32'(b_level), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
